fcf_hit_serializer: RTL and testbench

- Downstream of the fast cluster finder stage.
- Captures each 32-bit hit-location word (`to_serial`) qualified by `dataV` into a small FIFO.
- Emits each word as a framed single-bit stream on `BCclk`: header, 32 data bits MSB first, then idle low.
- Decouples bursty `dataV` from the fixed serial frame rate and reports overflow.

---
 rtl/fcf_hit_serializer.sv | 161 ++++++++++++++++
 tb/tb_fcf_hit_serializer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fcf_hit_serializer.sv
// Buffers 32-bit hit words from the fast cluster finder and streams each as a framed serial word on BCclk.
// Define FCF_SER_PARITY_EN to append an even-parity bit after word[0] (36-bit frames instead of 35).
module fcf_hit_serializer #(
    parameter int          DEPTH  = 4,
    parameter int          AW     = 2,
    parameter logic [2:0]  HEADER = 3'b101
) (
    input  logic          BCclk,
    input  logic          reset,
    input  logic          module_en,
    input  logic [31:0]   to_serial,
    input  logic          dataV,
    output logic          serial_out,
    output logic          frame_active,
    output logic [AW:0]   fifo_level,
    output logic          overflow,
    output logic [7:0]    drop_count
);

`ifdef FCF_SER_PARITY_EN
    localparam int F = 36;
`else
    localparam int F = 35;
`endif

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state, state_nx;
    logic [F-1:0]   shreg, shreg_nx;
    logic [5:0]     cnt, cnt_nx;
    logic           sout_nx, fa_nx;
    logic           pop, push, drop;
    logic           empty, full;
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [31:0]    mem [DEPTH];
    logic [31:0]    head;
    logic [F-1:0]   frame_load;

    assign empty = (fifo_level == '0);
    assign full  = (fifo_level == FULL_LVL);
    assign head  = mem[rd_ptr];

`ifdef FCF_SER_PARITY_EN
    assign frame_load = {HEADER, head, ^head};
`else
    assign frame_load = {HEADER, head};
`endif

    // cnt holds the number of frame bits still to follow the one on serial_out.
    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        cnt_nx   = cnt;
        sout_nx  = serial_out;
        fa_nx    = frame_active;
        pop      = 1'b0;
        if (!module_en) begin
            state_nx = IDLE;
            shreg_nx = '0;
            cnt_nx   = '0;
            sout_nx  = 1'b0;
            fa_nx    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        pop      = 1'b1;
                        shreg_nx = frame_load;
                        sout_nx  = frame_load[F-1];
                        fa_nx    = 1'b1;
                        cnt_nx   = 6'(F-1);
                        state_nx = SHIFT;
                    end else begin
                        sout_nx = 1'b0;
                        fa_nx   = 1'b0;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        shreg_nx = shreg << 1;
                        sout_nx  = shreg[F-2];
                        cnt_nx   = cnt - 6'd1;
                    end else if (!empty) begin
                        // Last bit is on the wire: chain the next frame with no idle bit.
                        pop      = 1'b1;
                        shreg_nx = frame_load;
                        sout_nx  = frame_load[F-1];
                        fa_nx    = 1'b1;
                        cnt_nx   = 6'(F-1);
                    end else begin
                        sout_nx  = 1'b0;
                        fa_nx    = 1'b0;
                        state_nx = IDLE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    sout_nx  = 1'b0;
                    fa_nx    = 1'b0;
                end
            endcase
        end
    end

    // A pop on the same edge frees the slot, so a full FIFO still accepts the word.
    assign push = dataV && module_en && (!full || pop);
    assign drop = dataV && module_en && full && !pop;

    always_ff @(posedge BCclk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            shreg        <= '0;
            cnt          <= '0;
            serial_out   <= 1'b0;
            frame_active <= 1'b0;
        end else begin
            state        <= state_nx;
            shreg        <= shreg_nx;
            cnt          <= cnt_nx;
            serial_out   <= sout_nx;
            frame_active <= fa_nx;
        end
    end

    always_ff @(posedge BCclk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (!module_en) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
                2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
                default: fifo_level <= fifo_level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF)
                    drop_count <= drop_count + 8'd1;
            end
        end
    end

    always_ff @(posedge BCclk) begin
        if (push)
            mem[wr_ptr] <= to_serial;
    end

endmodule

// File: tb/tb_fcf_hit_serializer.sv
// Scoreboard bench for fcf_hit_serializer: expected frame bits are queued when words are pushed
// and a monitor compares serial_out whenever frame_active is high.
module tb_fcf_hit_serializer;

`ifdef FCF_SER_PARITY_EN
    localparam int F = 36;
`else
    localparam int F = 35;
`endif

    logic        BCclk = 1'b0;
    logic        reset;
    logic        module_en;
    logic [31:0] to_serial;
    logic        dataV;
    logic        serial_out;
    logic        frame_active;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic [7:0]  drop_count;

    logic [0:0]  exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          sb_en    = 1'b0;

    fcf_hit_serializer #(.DEPTH(4), .AW(2), .HEADER(3'b101)) dut (
        .BCclk        (BCclk),
        .reset        (reset),
        .module_en    (module_en),
        .to_serial    (to_serial),
        .dataV        (dataV),
        .serial_out   (serial_out),
        .frame_active (frame_active),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    // clock / watchdog
    always #5 BCclk = ~BCclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model of one frame, MSB first
    task automatic enqueue(input logic [31:0] w);
        logic [F-1:0] fr;
`ifdef FCF_SER_PARITY_EN
        fr = {3'b101, w, ^w};
`else
        fr = {3'b101, w};
`endif
        for (int i = F - 1; i >= 0; i--)
            exp_q.push_back(fr[i]);
    endtask

    // driver: present a word for exactly one rising edge
    task automatic push(input logic [31:0] w, input bit acc);
        dataV     = 1'b1;
        to_serial = w;
        if (acc)
            enqueue(w);
        @(negedge BCclk);
        dataV = 1'b0;
    endtask

    task automatic measure_active(output int n);
        n = 0;
        while (frame_active && n < 400) begin
            n++;
            @(negedge BCclk);
        end
    endtask

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while ((fifo_level != 0 || frame_active) && c < 2000) begin
            c++;
            @(negedge BCclk);
        end
        chk(name, (c < 2000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // monitor / scoreboard
    always @(posedge BCclk) begin
        logic [0:0] e;
        #1;
        if (sb_en && !reset) begin
            if (frame_active) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame_bit", {31'd0, frame_active}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("serial_bit", {31'd0, serial_out}, {31'd0, e});
                end
            end else begin
                chk("idle_low", {31'd0, serial_out}, 32'd0);
            end
        end
    end

    // stimulus
    initial begin
        int n;
        reset     = 1'b1;
        module_en = 1'b0;
        dataV     = 1'b0;
        to_serial = '0;
        repeat (3) @(negedge BCclk);
        chk("rst_serial_out", {31'd0, serial_out}, 32'd0);
        chk("rst_frame_active", {31'd0, frame_active}, 32'd0);
        chk("rst_fifo_level", {29'd0, fifo_level}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_drop_count", {24'd0, drop_count}, 32'd0);
        reset     = 1'b0;
        module_en = 1'b1;
        sb_en     = 1'b1;
        @(negedge BCclk);

        // single word
        push(32'hA5A5_0F0F, 1'b1);
        chk("single_level_after_push", {29'd0, fifo_level}, 32'd1);
        @(negedge BCclk);
        chk("single_level_e1", {29'd0, fifo_level}, 32'd0);
        chk("single_active_e1", {31'd0, frame_active}, 32'd1);
        chk("single_header_bit", {31'd0, serial_out}, 32'd1);
        measure_active(n);
        chk("single_active_len", n, F);
        chk("single_queue_empty", exp_q.size(), 32'd0);
        repeat (3) @(negedge BCclk);

        // back-to-back
        push(32'h0000_0001, 1'b1);
        push(32'h8000_0000, 1'b1);
        chk("b2b_active", {31'd0, frame_active}, 32'd1);
        measure_active(n);
        chk("b2b_active_len", n, 2 * F);
        chk("b2b_queue_empty", exp_q.size(), 32'd0);
        repeat (2) @(negedge BCclk);

        // overflow
        push(32'h1111_0001, 1'b1);
        push(32'h2222_0002, 1'b1);
        push(32'h3333_0003, 1'b1);
        push(32'h4444_0004, 1'b1);
        push(32'h5555_0005, 1'b1);
        push(32'h6666_0006, 1'b0);
        chk("ovf_level", {29'd0, fifo_level}, 32'd4);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_drop_count", {24'd0, drop_count}, 32'd1);
        wait_drain("ovf_drain");
        chk("ovf_queue_empty", exp_q.size(), 32'd0);
        repeat (2) @(negedge BCclk);

        // enable abort 10 bits into a frame with 2 words queued
        push(32'h0F0F_F0F0, 1'b1);
        push(32'h1234_4321, 1'b1);
        push(32'hCAFE_F00D, 1'b1);
        chk("abort_level_before", {29'd0, fifo_level}, 32'd2);
        repeat (8) @(negedge BCclk);
        module_en = 1'b0;
        exp_q.delete();
        @(negedge BCclk);
        chk("abort_serial_out", {31'd0, serial_out}, 32'd0);
        chk("abort_frame_active", {31'd0, frame_active}, 32'd0);
        chk("abort_level", {29'd0, fifo_level}, 32'd0);
        chk("abort_overflow_held", {31'd0, overflow}, 32'd1);
        chk("abort_drop_held", {24'd0, drop_count}, 32'd1);
        repeat (2) @(negedge BCclk);
        module_en = 1'b1;
        @(negedge BCclk);
        push(32'hDEAD_BEEF, 1'b1);
        @(negedge BCclk);
        chk("reen_active", {31'd0, frame_active}, 32'd1);
        measure_active(n);
        chk("reen_active_len", n, F);
        chk("reen_queue_empty", exp_q.size(), 32'd0);

        // saturation: far more than 255 drops with stream bits unchecked
        sb_en = 1'b0;
        for (int i = 0; i < 330; i++)
            push(32'hFFFF_FFFF, 1'b0);
        chk("sat_drop_count", {24'd0, drop_count}, 32'd255);
        chk("sat_overflow", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 20; i++)
            push(32'hFFFF_FFFF, 1'b0);
        chk("sat_drop_stays", {24'd0, drop_count}, 32'd255);
        module_en = 1'b0;
        @(negedge BCclk);
        chk("sat_flush_level", {29'd0, fifo_level}, 32'd0);
        chk("sat_overflow_kept", {31'd0, overflow}, 32'd1);
        module_en = 1'b1;
        exp_q.delete();
        sb_en = 1'b1;
        @(negedge BCclk);

        // async reset mid-frame
        push(32'h1234_5678, 1'b1);
        repeat (5) @(negedge BCclk);
        chk("prereset_active", {31'd0, frame_active}, 32'd1);
        #2;
        exp_q.delete();
        reset = 1'b1;
        #1;
        chk("areset_serial_out", {31'd0, serial_out}, 32'd0);
        chk("areset_frame_active", {31'd0, frame_active}, 32'd0);
        chk("areset_level", {29'd0, fifo_level}, 32'd0);
        chk("areset_overflow", {31'd0, overflow}, 32'd0);
        chk("areset_drop_count", {24'd0, drop_count}, 32'd0);
        @(negedge BCclk);
        reset = 1'b0;
        repeat (2) @(negedge BCclk);
        chk("post_reset_idle", {31'd0, frame_active}, 32'd0);
        push(32'h0BAD_CAFE, 1'b1);
        @(negedge BCclk);
        measure_active(n);
        chk("post_reset_len", n, F);
        chk("post_reset_queue_empty", exp_q.size(), 32'd0);
        repeat (3) @(negedge BCclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
